ysyx_23060061_lsu: RTL

- Load/store unit sitting directly downstream of the ID/EX/WB decode-execute logic.
- Takes one memory request per instruction: address, store data and funct3 access type.
- Issues a word-aligned, byte-masked transaction to the data memory over a valid/ready + response handshake.
- Returns sign- or zero-extended load data, or a store-done pulse, to writeback; the core holds the PC until the response.

---
 rtl/ysyx_23060061_lsu.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060061_lsu.sv
// Load/store unit: one word-aligned, byte-masked memory transaction per request, with load extension and timeout.
// Optional build macro LSU_RANDOM_DELAY_EN inserts an LFSR-driven issue delay before each memory request.
module ysyx_23060061_lsu #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        f3_q, f3_n;
    logic [1:0]        off_q, off_n;
    logic              wen_q, wen_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic [3:0]        mask_q, mask_n;
    logic              err_q, err_n;
    logic              issue_ok;

    logic              req_bad;
    logic [3:0]        req_mask;
    logic [DATA_W-1:0] req_lane_data;

    // Selects the addressed byte/half from the aligned word and extends it per funct3.
    function automatic logic [DATA_W-1:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
            3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
            3'b100:  extend = {24'b0, sh[7:0]};
            3'b101:  extend = {16'b0, sh[15:0]};
            default: extend = word;
        endcase
    endfunction

    always_comb begin
        req_bad       = 1'b0;
        req_mask      = 4'b0000;
        req_lane_data = '0;
        if (req_wen) begin
            case (req_funct3)
                3'b000: begin
                    req_mask      = 4'b0001 << req_addr[1:0];
                    req_lane_data = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    req_mask      = 4'b0011 << req_addr[1:0];
                    req_lane_data = {2{req_wdata[15:0]}};
                    req_bad       = req_addr[0];
                end
                3'b010: begin
                    req_mask      = 4'b1111;
                    req_lane_data = req_wdata;
                    req_bad       = |req_addr[1:0];
                end
                default: req_bad = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_bad = 1'b0;
                3'b001, 3'b101: req_bad = req_addr[0];
                3'b010:         req_bad = |req_addr[1:0];
                default:        req_bad = 1'b1;
            endcase
        end
    end

`ifdef LSU_RANDOM_DELAY_EN
    logic [15:0] lfsr;
    logic [2:0]  dly, dly_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
            dly  <= 3'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            dly  <= dly_n;
        end
    end

    assign issue_ok = (dly == 3'd0);
`else
    assign issue_ok = 1'b1;
`endif

    assign req_ready     = (state == IDLE);
    assign resp_valid    = (state == RESP);
    assign mem_req_valid = (state == REQ) && issue_ok;
    assign mem_wen       = wen_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = mask_q;
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the case infers a latch.
        state_n = state;
        cnt_n   = cnt;
        f3_n    = f3_q;
        off_n   = off_q;
        wen_n   = wen_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        mask_n  = mask_q;
        rdata_n = rdata_q;
        err_n   = err_q;
`ifdef LSU_RANDOM_DELAY_EN
        dly_n   = dly;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    f3_n    = req_funct3;
                    off_n   = req_addr[1:0];
                    rdata_n = '0;
                    err_n   = 1'b0;
                    if (req_bad) begin
                        err_n   = 1'b1;
                        state_n = RESP;
                    end else begin
                        wen_n   = req_wen;
                        addr_n  = {req_addr[ADDR_W-1:2], 2'b00};
                        wdata_n = req_wen ? req_lane_data : '0;
                        mask_n  = req_wen ? req_mask : 4'b0000;
                        state_n = REQ;
`ifdef LSU_RANDOM_DELAY_EN
                        dly_n   = lfsr[2:0];
`endif
                    end
                end
            end
            REQ: begin
`ifdef LSU_RANDOM_DELAY_EN
                if (dly != 3'd0) dly_n = dly - 3'd1;
`endif
                if (mem_req_valid && mem_req_ready) begin
                    cnt_n = '0;
                    if (mem_resp_valid) begin
                        if (!wen_q) rdata_n = extend(f3_q, off_q, mem_rdata);
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (!wen_q) rdata_n = extend(f3_q, off_q, mem_rdata);
                    state_n = RESP;
                end else if (cnt == CNT_LAST) begin
                    err_n   = 1'b1;
                    rdata_n = '0;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= 4'b0000;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values regardless of order.
            state   <= state_n;
            cnt     <= cnt_n;
            f3_q    <= f3_n;
            off_q   <= off_n;
            wen_q   <= wen_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            mask_q  <= mask_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
        end
    end

endmodule
